counter_param: RTL and testbench

//  Parametrised successor to the 4-bit mode counter. Counts with a

---
 rtl/counter_param.sv | 111 +++++++++++
 tb/tb_counter_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_param.sv
// Parametrised up/down/step/load counter with run-time terminal value,
// wrap-or-clamp overflow handling and a saturating count of rollovers.
module counter_param #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             load,
  output logic [CNT_W-1:0] rco_cnt
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH:0] INC_ONE  = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] INC_STEP = (WIDTH+1)'(STEP);

  logic [WIDTH-1:0] r_q;
  logic             r_rco;
  logic             r_load;
  logic [CNT_W-1:0] r_rcoCnt;

  logic [WIDTH:0]   w_qExt;
  logic [WIDTH:0]   w_limExt;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap;
  logic             w_cntFull;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextRco;
  logic             w_nextLoad;

  // Arithmetic is one bit wider than Q so the up sum cannot overflow silently.
  assign w_qExt    = {1'b0, r_q};
  assign w_limExt  = {1'b0, limit};
  assign w_inc     = (mode == MODE_STEP) ? INC_STEP : INC_ONE;
  assign w_sum     = w_qExt + w_inc;
  assign w_wrap    = w_sum - w_limExt - INC_ONE;
  assign w_cntFull = &r_rcoCnt;

  always_comb begin
    w_nextQ    = r_q;
    w_nextRco  = 1'b0;
    w_nextLoad = 1'b0;
    if (enable) begin
      case (mode)
        MODE_UP, MODE_STEP: begin
          if (w_qExt > w_limExt) begin
            w_nextQ   = sat ? limit : '0;
            w_nextRco = 1'b1;
          end else if (w_sum <= w_limExt) begin
            w_nextQ = w_sum[WIDTH-1:0];
          end else if (!sat) begin
            w_nextQ   = (w_wrap > w_limExt) ? '0 : w_wrap[WIDTH-1:0];
            w_nextRco = 1'b1;
          end else if (r_q != limit) begin
            w_nextQ   = limit;
            w_nextRco = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (r_q != '0) begin
            w_nextQ = r_q - 1'b1;
          end else if (!sat) begin
            w_nextQ   = limit;
            w_nextRco = 1'b1;
          end
        end
        MODE_LOAD: begin
          w_nextQ    = D;
          w_nextLoad = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q      <= '0;
      r_rco    <= 1'b0;
      r_load   <= 1'b0;
      r_rcoCnt <= '0;
    end else begin
      r_q    <= w_nextQ;
      r_rco  <= w_nextRco;
      r_load <= w_nextLoad;
      if (w_nextRco && !w_cntFull) begin
        r_rcoCnt <= r_rcoCnt + 1'b1;
      end
    end
  end

  assign Q       = r_q;
  assign rco     = r_rco;
  assign load    = r_load;
  assign rco_cnt = r_rcoCnt;

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: integer reference model checked every cycle,
// plus directed vectors with hand-computed expectations.
module tb_counter_param;

  localparam int WIDTH   = 4;
  localparam int STEP    = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b1;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] D = '0;
  logic [WIDTH-1:0] limit = '0;
  logic             sat = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             rco;
  logic             load;
  logic [CNT_W-1:0] rco_cnt;

  int nVectors = 0;
  int nMiscompares = 0;

  int mQ = 0;
  int mCnt = 0;
  int mRco = 0;
  int mLoad = 0;
  bit modelValid = 1'b0;

  always #5 clk = ~clk;

  counter_param #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .D(D),
    .limit(limit), .sat(sat), .Q(Q), .rco(rco), .load(load), .rco_cnt(rco_cnt)
  );

  function automatic void checkOutput(string name, int actual, int expected);
    nVectors++;
    if (actual != expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endfunction

  // Reference model: the counting rules evaluated on plain integers.
  always @(posedge clk) begin
    int lim;
    int s;
    lim = int'(limit);
    if (reset) begin
      mQ = 0; mRco = 0; mLoad = 0; mCnt = 0;
    end else begin
      mRco = 0;
      mLoad = 0;
      if (enable) begin
        if (mode == 2'b00 || mode == 2'b10) begin
          s = mQ + ((mode == 2'b10) ? STEP : 1);
          if (mQ > lim) begin
            mQ = sat ? lim : 0;
            mRco = 1;
          end else if (s <= lim) begin
            mQ = s;
          end else if (!sat) begin
            mQ = (s - (lim + 1) > lim) ? 0 : s - (lim + 1);
            mRco = 1;
          end else if (mQ != lim) begin
            mQ = lim;
            mRco = 1;
          end
        end else if (mode == 2'b01) begin
          if (mQ > 0) mQ = mQ - 1;
          else if (!sat) begin
            mQ = lim;
            mRco = 1;
          end
        end else begin
          mQ = int'(D);
          mLoad = 1;
        end
      end
      if (mRco == 1 && mCnt < CNT_MAX) mCnt = mCnt + 1;
    end
    modelValid = 1'b1;
  end

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("modelQ", int'(Q), mQ);
      checkOutput("modelRco", int'(rco), mRco);
      checkOutput("modelLoad", int'(load), mLoad);
      checkOutput("modelRcoCnt", int'(rco_cnt), mCnt);
    end
  end

  task automatic applyStimulus(input logic r, input logic en, input logic [1:0] m,
                               input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] lim,
                               input logic s);
    @(negedge clk);
    reset = r; enable = en; mode = m; D = d; limit = lim; sat = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) begin
      applyStimulus(1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
      checkOutput("rstQ", int'(Q), 0);
      checkOutput("rstRco", int'(rco), 0);
      checkOutput("rstLoad", int'(load), 0);
      checkOutput("rstCnt", int'(rco_cnt), 0);
    end

    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd9, 1'b0);
      checkOutput("upQ", int'(Q), (i == 10) ? 0 : i);
      checkOutput("upRco", int'(rco), (i == 10) ? 1 : 0);
    end
    checkOutput("upCnt", int'(rco_cnt), 1);

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd14, 4'd15, 1'b0);
    checkOutput("load14Q", int'(Q), 14);
    checkOutput("load14Load", int'(load), 1);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd15, 1'b0);
    checkOutput("stepWrapQ", int'(Q), 1);
    checkOutput("stepWrapRco", int'(rco), 1);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd15, 1'b0);
    checkOutput("stepQ", int'(Q), 4);
    checkOutput("stepRco", int'(rco), 0);
    checkOutput("stepCnt", int'(rco_cnt), 2);

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd8, 4'd9, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd9, 1'b1);
    checkOutput("satClampQ", int'(Q), 9);
    checkOutput("satClampRco", int'(rco), 1);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd9, 1'b1);
    checkOutput("satHoldQ", int'(Q), 9);
    checkOutput("satHoldRco", int'(rco), 0);
    applyStimulus(1'b0, 1'b1, 2'b11, 4'd0, 4'd9, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b1);
    checkOutput("satDownQ", int'(Q), 0);
    checkOutput("satDownRco", int'(rco), 0);

    applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    checkOutput("downWrapQ", int'(Q), 9);
    checkOutput("downWrapRco", int'(rco), 1);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    checkOutput("downQ", int'(Q), 8);

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd12, 4'd9, 1'b0);
    checkOutput("loadHighQ", int'(Q), 12);
    checkOutput("loadHighLoad", int'(load), 1);
    checkOutput("loadHighRco", int'(rco), 0);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd9, 1'b0);
    checkOutput("overQ", int'(Q), 0);
    checkOutput("overRco", int'(rco), 1);
    checkOutput("overLoad", int'(load), 0);
    checkOutput("overCnt", int'(rco_cnt), 5);

    // Step overshoot that still lands above limit after one wrap falls to 0.
    applyStimulus(1'b0, 1'b1, 2'b11, 4'd1, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b10, 4'd0, 4'd1, 1'b0);
    checkOutput("doubleWrapQ", int'(Q), 0);
    checkOutput("doubleWrapRco", int'(rco), 1);

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd12, 4'd9, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd9, 1'b0);
    checkOutput("downAboveQ", int'(Q), 11);
    checkOutput("downAboveRco", int'(rco), 0);
    applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd9, 1'b1);
    checkOutput("satOverQ", int'(Q), 9);
    checkOutput("satOverRco", int'(rco), 1);
    checkOutput("satOverCnt", int'(rco_cnt), 7);

    applyStimulus(1'b1, 1'b1, 2'b00, 4'd0, 4'd9, 1'b0);
    checkOutput("midRstQ", int'(Q), 0);
    checkOutput("midRstCnt", int'(rco_cnt), 0);

    applyStimulus(1'b0, 1'b1, 2'b01, 4'd0, 4'd0, 1'b0);
    checkOutput("lim0DownQ", int'(Q), 0);
    checkOutput("lim0DownRco", int'(rco), 1);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 1'b0);
      checkOutput("lim0UpRco", int'(rco), 1);
    end
    checkOutput("lim0UpQ", int'(Q), 0);
    checkOutput("cntSat", int'(rco_cnt), 255);

    applyStimulus(1'b1, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0);
    checkOutput("rstDisQ", int'(Q), 0);
    checkOutput("rstDisCnt", int'(rco_cnt), 0);

    applyStimulus(1'b0, 1'b1, 2'b11, 4'd5, 4'd9, 1'b0);
    checkOutput("load5Q", int'(Q), 5);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 2'b00, 4'd0, 4'd9, 1'b0);
      checkOutput("holdQ", int'(Q), 5);
      checkOutput("holdRco", int'(rco), 0);
      checkOutput("holdLoad", int'(load), 0);
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
